mopshub_init_sequencer: RTL and testbench

- Power-up/initialisation sequencer for the 16-bus MOPSHUB top level.
- After reset it pulses the bus reset, then powers each CAN bus in turn. Per bus it optionally runs an oscillator-trim handshake.
- It then asserts sign-on and holds it until the system releases it with endwait_all.
- Its outputs feed the bus power switches, the trim engine and the testbench activity monitors.

---
 rtl/mopshub_init_sequencer_if.sv | 37 +++
 rtl/mopshub_init_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mopshub_init_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mopshub_init_sequencer_if.sv
// rtl/mopshub_init_sequencer_if.sv - control/status bundle between the init sequencer and the MOPSHUB top level
// Purpose: groups the sequencer's system-side inputs and all of its status outputs.
// Ports (signals):
//   inputs to sequencer : n_buses[4:0], osc_auto_trim_mopshub, trim_done_in, endwait_all
//   outputs of sequencer: start_init, rst_bus, power_bus_en, power_bus_cnt[4:0], start_trim_ack,
//                         start_osc_cnt, end_trim_bus, end_power_init, sign_on_sig, end_init, trim_timeout
// Modports: master = sequencer side, slave = system side.
interface mopshub_init_sequencer_if;
    logic [4:0] n_buses;
    logic       osc_auto_trim_mopshub;
    logic       trim_done_in;
    logic       endwait_all;

    logic       start_init;
    logic       rst_bus;
    logic       power_bus_en;
    logic [4:0] power_bus_cnt;
    logic       start_trim_ack;
    logic       start_osc_cnt;
    logic       end_trim_bus;
    logic       end_power_init;
    logic       sign_on_sig;
    logic       end_init;
    logic       trim_timeout;

    modport master (
        input  n_buses, osc_auto_trim_mopshub, trim_done_in, endwait_all,
        output start_init, rst_bus, power_bus_en, power_bus_cnt, start_trim_ack,
               start_osc_cnt, end_trim_bus, end_power_init, sign_on_sig, end_init, trim_timeout
    );

    modport slave (
        output n_buses, osc_auto_trim_mopshub, trim_done_in, endwait_all,
        input  start_init, rst_bus, power_bus_en, power_bus_cnt, start_trim_ack,
               start_osc_cnt, end_trim_bus, end_power_init, sign_on_sig, end_init, trim_timeout
    );
endinterface

// File: rtl/mopshub_init_sequencer.sv
// rtl/mopshub_init_sequencer.sv - power-up sequencer: bus reset, per-bus power/trim, sign-on
// Purpose: after reset pulses rst_bus, powers buses 0..min(n_buses,15) one at a time with an
//   optional oscillator-trim handshake per bus, then holds sign-on until endwait_all.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   bus_if - mopshub_init_sequencer_if.master (control inputs, registered status outputs)
// Optional: define MOPSHUB_TRIM_TIMEOUT_EN to abandon a trim after TRIM_TIMEOUT cycles and set
//   the sticky trim_timeout flag; otherwise TRIM_WAIT waits indefinitely and trim_timeout is 0.
module mopshub_init_sequencer #(
    parameter int RST_BUS_CYCLES = 8,
    parameter int POWER_WAIT     = 16,
    parameter int TRIM_TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    mopshub_init_sequencer_if.master       bus_if
);
    localparam int MAX_AB  = (RST_BUS_CYCLES > POWER_WAIT) ? RST_BUS_CYCLES : POWER_WAIT;
    localparam int CNT_MAX = (MAX_AB > TRIM_TIMEOUT) ? MAX_AB : TRIM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_RSTBUS, S_POWER, S_TRIM_REQ, S_TRIM_WAIT, S_NEXT, S_SIGNON, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bus_q, bus_d;
    logic [4:0]    last_q, last_d;
    logic          start_init_q, start_init_d;
    logic          rst_bus_q, rst_bus_d;
    logic          power_en_q, power_en_d;
    logic          ack_q, ack_d;
    logic          osc_q, osc_d;
    logic          end_trim_q, end_trim_d;
    logic          end_power_q, end_power_d;
    logic          sign_on_q, sign_on_d;
    logic          end_init_q, end_init_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bus_q        <= '0;
            last_q       <= '0;
            start_init_q <= 1'b0;
            rst_bus_q    <= 1'b0;
            power_en_q   <= 1'b0;
            ack_q        <= 1'b0;
            osc_q        <= 1'b0;
            end_trim_q   <= 1'b0;
            end_power_q  <= 1'b0;
            sign_on_q    <= 1'b0;
            end_init_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_q        <= bus_d;
            last_q       <= last_d;
            start_init_q <= start_init_d;
            rst_bus_q    <= rst_bus_d;
            power_en_q   <= power_en_d;
            ack_q        <= ack_d;
            osc_q        <= osc_d;
            end_trim_q   <= end_trim_d;
            end_power_q  <= end_power_d;
            sign_on_q    <= sign_on_d;
            end_init_q   <= end_init_d;
            timeout_q    <= timeout_d;
        end
    end

    // Output registers are loaded with the value belonging to the state being entered,
    // so every output is a flop aligned with its state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_d        = bus_q;
        last_d       = last_q;
        timeout_d    = timeout_q;
        start_init_d = 1'b0;
        rst_bus_d    = 1'b0;
        power_en_d   = 1'b0;
        ack_d        = 1'b0;
        osc_d        = 1'b0;
        end_trim_d   = 1'b0;
        end_power_d  = 1'b0;
        sign_on_d    = 1'b0;
        end_init_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d      = S_START;
                start_init_d = 1'b1;
            end
            S_START: begin
                last_d    = (bus_if.n_buses > 5'd15) ? 5'd15 : bus_if.n_buses;
                state_d   = S_RSTBUS;
                cnt_d     = '0;
                rst_bus_d = 1'b1;
            end
            S_RSTBUS: begin
                if (cnt_q == CW'(RST_BUS_CYCLES - 1)) begin
                    state_d    = S_POWER;
                    cnt_d      = '0;
                    bus_d      = '0;
                    power_en_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    rst_bus_d = 1'b1;
                end
            end
            S_POWER: begin
                if (cnt_q == CW'(POWER_WAIT - 1)) begin
                    cnt_d = '0;
                    if (bus_if.osc_auto_trim_mopshub) begin
                        state_d    = S_TRIM_REQ;
                        ack_d      = 1'b1;
                        power_en_d = 1'b1;
                    end else begin
                        state_d     = S_NEXT;
                        end_power_d = (bus_q == last_q);
                    end
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    power_en_d = 1'b1;
                end
            end
            S_TRIM_REQ: begin
                state_d    = S_TRIM_WAIT;
                cnt_d      = '0;
                osc_d      = 1'b1;
                power_en_d = 1'b1;
            end
            S_TRIM_WAIT: begin
                // trim_done_in wins over a timeout expiring in the same cycle
                if (bus_if.trim_done_in) begin
                    state_d     = S_NEXT;
                    end_trim_d  = 1'b1;
                    end_power_d = (bus_q == last_q);
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
                end else if (cnt_q == CW'(TRIM_TIMEOUT - 1)) begin
                    state_d     = S_NEXT;
                    end_trim_d  = 1'b1;
                    timeout_d   = 1'b1;
                    end_power_d = (bus_q == last_q);
`endif
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    osc_d      = 1'b1;
                    power_en_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (bus_q == last_q) begin
                    state_d   = S_SIGNON;
                    sign_on_d = 1'b1;
                end else begin
                    state_d    = S_POWER;
                    bus_d      = bus_q + 5'd1;
                    cnt_d      = '0;
                    power_en_d = 1'b1;
                end
            end
            S_SIGNON: begin
                if (bus_if.endwait_all) begin
                    state_d    = S_DONE;
                    end_init_d = 1'b1;
                end else begin
                    sign_on_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_if.start_init     = start_init_q;
    assign bus_if.rst_bus        = rst_bus_q;
    assign bus_if.power_bus_en   = power_en_q;
    assign bus_if.power_bus_cnt  = bus_q;
    assign bus_if.start_trim_ack = ack_q;
    assign bus_if.start_osc_cnt  = osc_q;
    assign bus_if.end_trim_bus   = end_trim_q;
    assign bus_if.end_power_init = end_power_q;
    assign bus_if.sign_on_sig    = sign_on_q;
    assign bus_if.end_init       = end_init_q;
    assign bus_if.trim_timeout   = timeout_q;
endmodule

// File: tb/tb_mopshub_init_sequencer.sv
// tb/tb_mopshub_init_sequencer.sv - directed self-checking bench for mopshub_init_sequencer
module tb_mopshub_init_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mopshub_init_sequencer_if sig ();

    mopshub_init_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (sig)
    );

    always #5 clk = ~clk;

    int c, n_start, c_start, n_rb, rb_first, rb_last, n_pwr, n_rise, n_gap;
    int n_endpwr, c_endpwr, bus_endpwr, c_signon, n_ack, n_osc, n_endtrim, n_endinit;
    int max_bus, wrap;
    logic prev_en;
    int   prev_bus;

    always @(negedge clk) begin
        if (rst) begin
            c = 0; n_start = 0; c_start = 0; n_rb = 0; rb_first = 0; rb_last = 0;
            n_pwr = 0; n_rise = 0; n_gap = 0; n_endpwr = 0; c_endpwr = 0; bus_endpwr = 0;
            c_signon = 0; n_ack = 0; n_osc = 0; n_endtrim = 0; n_endinit = 0;
            max_bus = 0; wrap = 0; prev_en = 1'b0; prev_bus = 0;
        end else begin
            c++;
            if (sig.start_init) begin n_start++; c_start = c; end
            if (sig.rst_bus) begin
                if (n_rb == 0) rb_first = c;
                rb_last = c;
                n_rb++;
            end
            if (sig.power_bus_en) begin
                n_pwr++;
                if (!prev_en) n_rise++;
            end else if (n_rise > 0 && n_endpwr == 0) begin
                n_gap++;
            end
            prev_en = sig.power_bus_en;
            if (sig.end_power_init) begin
                n_endpwr++; c_endpwr = c; bus_endpwr = int'(sig.power_bus_cnt);
            end
            if (sig.sign_on_sig && c_signon == 0) c_signon = c;
            if (int'(sig.power_bus_cnt) < prev_bus) wrap = 1;
            if (int'(sig.power_bus_cnt) > max_bus) max_bus = int'(sig.power_bus_cnt);
            prev_bus = int'(sig.power_bus_cnt);
            if (sig.start_trim_ack) n_ack++;
            if (sig.start_osc_cnt)  n_osc++;
            if (sig.end_trim_bus)   n_endtrim++;
            if (sig.end_init)       n_endinit++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {sig.start_init, sig.rst_bus, sig.power_bus_en, sig.start_trim_ack, sig.start_osc_cnt,
                sig.end_trim_bus, sig.end_power_init, sig.sign_on_sig, sig.end_init, sig.trim_timeout};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // which: 0 = sign_on_sig, 1 = start_trim_ack, 2 = power_bus_en
    task automatic wait_for(input int which, input int limit, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step(1);
            case (which)
                0: seen = sig.sign_on_sig;
                1: seen = sig.start_trim_ack;
                default: seen = sig.power_bus_en;
            endcase
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic start_run(input logic [4:0] nb, input logic auto_trim);
        rst = 1'b1;
        sig.n_buses = nb;
        sig.osc_auto_trim_mopshub = auto_trim;
        sig.trim_done_in = 1'b0;
        sig.endwait_all = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    task automatic trim_respond();
        step(10);
        sig.trim_done_in = 1'b1;
        step(1);
        sig.trim_done_in = 1'b0;
    endtask

    initial begin
        sig.n_buses = 5'd15;
        sig.osc_auto_trim_mopshub = 1'b0;
        sig.trim_done_in = 1'b0;
        sig.endwait_all = 1'b0;
        step(2);
        check("reset_outs", {22'd0, outs()}, 32'd0);
        check("reset_cnt", {27'd0, sig.power_bus_cnt}, 32'd0);

        // 16 buses, no trim, endwait_all pulsed during POWER
        start_run(5'd15, 1'b0);
        step(50);
        sig.endwait_all = 1'b1;
        step(1);
        sig.endwait_all = 1'b0;
        wait_for(0, 1000, "t1_signon_wait");
        check("t1_start_cyc", c_start, 1);
        check("t1_start_n", n_start, 1);
        check("t1_rstbus_n", n_rb, 8);
        check("t1_rstbus_first", rb_first, 2);
        check("t1_rstbus_last", rb_last, 9);
        check("t1_pwr_cycles", n_pwr, 256);
        check("t1_pwr_rises", n_rise, 16);
        check("t1_pwr_gaps", n_gap, 16);
        check("t1_endpwr_n", n_endpwr, 1);
        check("t1_endpwr_cyc", c_endpwr, 281);
        check("t1_endpwr_bus", bus_endpwr, 15);
        check("t1_signon_cyc", c_signon, 282);
        check("t1_no_early_endinit", n_endinit, 0);
        check("t1_no_ack", n_ack, 0);
        step(100);
        check("t1_signon_held", {31'd0, sig.sign_on_sig}, 32'd1);
        sig.endwait_all = 1'b1;
        step(1);
        sig.endwait_all = 1'b0;
        check("t1_signon_fall", {31'd0, sig.sign_on_sig}, 32'd0);
        check("t1_endinit_pulse", {31'd0, sig.end_init}, 32'd1);
        step(50);
        check("t1_endinit_once", n_endinit, 1);
        check("t1_done_outs", {22'd0, outs()}, 32'd0);
        check("t1_done_cnt", {27'd0, sig.power_bus_cnt}, 32'd15);
        check("t1_done_pwr", n_pwr, 256);

        // 3 buses with trim, stray trim_done_in during POWER of bus 0
        start_run(5'd2, 1'b1);
        step(12);
        sig.trim_done_in = 1'b1;
        step(1);
        sig.trim_done_in = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wait_for(1, 200, "t2_ack_wait");
            trim_respond();
        end
        wait_for(0, 200, "t2_signon_wait");
        check("t2_ack_n", n_ack, 3);
        check("t2_endtrim_n", n_endtrim, 3);
        check("t2_osc_cycles", n_osc, 30);
        check("t2_timeout", {31'd0, sig.trim_timeout}, 32'd0);
        check("t2_pwr_cycles", n_pwr, 81);
        check("t2_endpwr_cyc", c_endpwr, 93);
        check("t2_endpwr_bus", bus_endpwr, 2);
        check("t2_signon_cyc", c_signon, 94);

        // n_buses above 15 clamps to 15
        start_run(5'd20, 1'b0);
        wait_for(0, 1000, "t3_signon_wait");
        check("t3_endpwr_bus", bus_endpwr, 15);
        check("t3_max_bus", max_bus, 15);
        check("t3_no_wrap", wrap, 0);
        check("t3_endpwr_cyc", c_endpwr, 281);
        sig.n_buses = 5'd0;
        step(5);
        check("t3_cnt_hold", {27'd0, sig.power_bus_cnt}, 32'd15);

`ifdef MOPSHUB_TRIM_TIMEOUT_EN
        // trim never completes: each bus abandons after 64 cycles
        start_run(5'd1, 1'b1);
        wait_for(0, 2000, "t5_signon_wait");
        check("t5_endtrim_n", n_endtrim, 2);
        check("t5_osc_cycles", n_osc, 128);
        check("t5_timeout", {31'd0, sig.trim_timeout}, 32'd1);
`endif

        // reset during TRIM_WAIT of bus 5
        start_run(5'd15, 1'b1);
        for (int b = 0; b < 5; b++) begin
            wait_for(1, 200, "t4_ack_wait");
            trim_respond();
        end
        wait_for(1, 200, "t4_ack5_wait");
        step(3);
        check("t4_bus5", {27'd0, sig.power_bus_cnt}, 32'd5);
        check("t4_osc_before", {31'd0, sig.start_osc_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_async_outs", {22'd0, outs()}, 32'd0);
        check("t4_async_cnt", {27'd0, sig.power_bus_cnt}, 32'd0);
        step(2);
        rst = 1'b0;
        wait_for(2, 100, "t4_pwr_wait");
        check("t4_restart_start", c_start, 1);
        check("t4_restart_bus", {27'd0, sig.power_bus_cnt}, 32'd0);
        check("t4_restart_pwr_cyc", c, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
